alu_execute_stage: RTL
======================

Name: alu_execute_stage

Overview:
- Execute stage directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU operation code plus ID/EX operands and performs the operation.
- Registers the result and the forwarded memory/writeback controls into the EX/MEM pipeline latch.
- Stall, flush and bubble handling make it the sequential boundary between EX and MEM.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- REG_ADDR_WIDTH, 5, destination register index width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hold latch contents (hazard unit)
- flush  in  1  insert bubble (branch taken / exception)
- inValid  in  1  ID/EX slot holds a real instruction
- aluOperation  in  4  0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT, others illegal (0xF = decoder default)
- operandA  in  DATA_WIDTH  rs value / base
- operandB  in  DATA_WIDTH  rt value or sign-extended immediate
- shamt  in  5  instruction shift-amount field
- shiftVariable  in  1  1: shift amount = operandA[4:0] (SLLV/SRLV/SRAV)
- writeRegIn  in  REG_ADDR_WIDTH  destination register
- regWriteIn, memReadIn, memWriteIn  in  1 each  downstream controls
- storeDataIn  in  DATA_WIDTH  rt value for stores
- outValid  out  1  EX/MEM slot valid
- aluResult  out  DATA_WIDTH  registered result
- zero  out  1  registered (aluResult == 0)
- overflow  out  1  registered signed overflow, ADD/SUB only
- illegalOp  out  1  registered: valid instruction carried an unsupported code
- illegalSeen  out  1  sticky illegalOp, cleared only by reset
- writeRegOut, regWriteOut, memReadOut, memWriteOut, storeDataOut  out  as inputs  registered controls

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs 0; takes effect immediately, mid-operation included.
- Latency: 1 cycle; inputs sampled at a rising edge appear on outputs after that edge.
- Per-edge priority: flush > stall > load.
  - flush=1: bubble loaded. outValid, regWriteOut, memReadOut, memWriteOut, illegalOp = 0; aluResult, storeDataOut, writeRegOut = 0; overflow = 0; zero = 1 (consistent with result 0). Flush overrides a simultaneous stall.
  - stall=1, flush=0: every output holds, illegalSeen included.
  - Otherwise: load. inValid=0 loads a bubble, identical to flush.
- Shifts operate on operandB; amount = shiftVariable ? operandA[4:0] : shamt.
- SRA is arithmetic (sign-filled); SLL/SRL are zero-filled.
- ADD/SUB: modulo 2^DATA_WIDTH. overflow = operands of equal sign (for SUB: A and ~B) with result sign differing. overflow = 0 for every other op; never traps, never suppresses writeback.
- SLT: signed compare; result 1 or 0, zero-extended.
- NOR = ~(A|B).
- Illegal code (10–15) with inValid=1: aluResult=0, illegalOp=1, regWriteOut=memReadOut=memWriteOut=0, outValid=1, illegalSeen set.
- zero is computed from the final (post-illegal-masking) result.
- No internal state beyond the latch and illegalSeen.

Decomposition:
- Shared package: ALU op-code constants (ALU_SLL=0 … ALU_SLT=9, ALU_ILLEGAL=4'hF), DATA_WIDTH/REG_ADDR_WIDTH defaults. The control decoder uses the same constants.
- One combinational sub-module, alu_core (aluOperation, a, b, shiftAmount -> result, overflow, illegal). The stage instantiates it and owns the latch, priority logic and sticky flag.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> all outputs 0. Assert reset_n low mid-stream, asynchronously between edges -> outputs 0 before the next edge.
- Arithmetic: ADD 0x7FFFFFFF+1 -> aluResult=0x80000000, overflow=1. SUB 5-5 -> 0, zero=1, overflow=0. SLT A=0xFFFFFFFF, B=1 -> 1.
- Shifts: SRA B=0x80000000, shamt=4 -> 0xF8000000. SRLV A=0x24 (amount 4), B=0xF0 -> 0x0F, shamt ignored. SLL shamt=31, B=1 -> 0x80000000.
- Stall/flush: load ADD (result 0x10), then stall 3 cycles with new inputs -> outputs hold 0x10. Assert stall+flush together -> bubble (outValid=0, regWriteOut=0, zero=1).
- Illegal op: aluOperation=0xF, inValid=1, regWriteIn=1 -> aluResult=0, illegalOp=1, regWriteOut=0. Next cycle legal ADD -> illegalOp=0, illegalSeen stays 1 until reset.
- Bubble: inValid=0, memWriteIn=1 -> memWriteOut=0, outValid=0. Back-to-back valid ops -> one result per cycle, no gaps.

Source files
------------

// File: rtl/alu_execute_stage_pkg.sv
// Shared ALU op-code constants and default widths for the decoder and the execute stage.
package alu_execute_stage_pkg;

  localparam int unsigned DefaultDataWidth    = 32;
  localparam int unsigned DefaultRegAddrWidth = 5;
  localparam int unsigned ShiftAmtWidth       = 5;

  localparam logic [3:0] ALU_SLL     = 4'd0;
  localparam logic [3:0] ALU_SRL     = 4'd1;
  localparam logic [3:0] ALU_SRA     = 4'd2;
  localparam logic [3:0] ALU_ADD     = 4'd3;
  localparam logic [3:0] ALU_SUB     = 4'd4;
  localparam logic [3:0] ALU_AND     = 4'd5;
  localparam logic [3:0] ALU_OR      = 4'd6;
  localparam logic [3:0] ALU_XOR     = 4'd7;
  localparam logic [3:0] ALU_NOR     = 4'd8;
  localparam logic [3:0] ALU_SLT     = 4'd9;
  localparam logic [3:0] ALU_ILLEGAL = 4'hF;

endpackage

// File: rtl/alu_execute_stage_alu_core.sv
// Purely combinational ALU: result, signed overflow (ADD/SUB only) and illegal-code flag.
module alu_core
  import alu_execute_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
  input  logic [3:0]               aluOperation,
  input  logic [DATA_WIDTH-1:0]    a,
  input  logic [DATA_WIDTH-1:0]    b,
  input  logic [ShiftAmtWidth-1:0] shiftAmount,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     overflow,
  output logic                     illegal
);

  localparam int unsigned Msb = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] diff;
  logic                  add_ovf;
  logic                  sub_ovf;
  logic                  lt;

  assign sum  = a + b;
  assign diff = a - b;
  // Signed overflow: operands agree in sign (SUB compares A with ~B) but result sign differs.
  assign add_ovf = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
  assign sub_ovf = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
  assign lt      = $signed(a) < $signed(b);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (aluOperation)
      ALU_SLL: result = b << shiftAmount;
      ALU_SRL: result = b >> shiftAmount;
      ALU_SRA: result = $unsigned($signed(b) >>> shiftAmount);
      ALU_ADD: begin
        result   = sum;
        overflow = add_ovf;
      end
      ALU_SUB: begin
        result   = diff;
        overflow = sub_ovf;
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {{(DATA_WIDTH-1){1'b0}}, lt};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_execute_stage.sv
// EX stage: runs the ALU on the ID/EX operands and registers result plus MEM/WB controls
// into the EX/MEM latch with flush > stall > load priority.
module alu_execute_stage
  import alu_execute_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DefaultDataWidth,
  parameter int unsigned REG_ADDR_WIDTH = DefaultRegAddrWidth
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      inValid,
  input  logic [3:0]                aluOperation,
  input  logic [DATA_WIDTH-1:0]     operandA,
  input  logic [DATA_WIDTH-1:0]     operandB,
  input  logic [4:0]                shamt,
  input  logic                      shiftVariable,
  input  logic [REG_ADDR_WIDTH-1:0] writeRegIn,
  input  logic                      regWriteIn,
  input  logic                      memReadIn,
  input  logic                      memWriteIn,
  input  logic [DATA_WIDTH-1:0]     storeDataIn,
  output logic                      outValid,
  output logic [DATA_WIDTH-1:0]     aluResult,
  output logic                      zero,
  output logic                      overflow,
  output logic                      illegalOp,
  output logic                      illegalSeen,
  output logic [REG_ADDR_WIDTH-1:0] writeRegOut,
  output logic                      regWriteOut,
  output logic                      memReadOut,
  output logic                      memWriteOut,
  output logic [DATA_WIDTH-1:0]     storeDataOut
);

  logic [ShiftAmtWidth-1:0] shift_amount;
  logic [DATA_WIDTH-1:0]    core_result;
  logic                     core_overflow;
  logic                     core_illegal;

  assign shift_amount = shiftVariable ? operandA[ShiftAmtWidth-1:0] : shamt;

  alu_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu_core (
    .aluOperation (aluOperation),
    .a            (operandA),
    .b            (operandB),
    .shiftAmount  (shift_amount),
    .result       (core_result),
    .overflow     (core_overflow),
    .illegal      (core_illegal)
  );

  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     result_q, result_d;
  logic                      zero_q, zero_d;
  logic                      ovf_q, ovf_d;
  logic                      illegal_q, illegal_d;
  logic                      seen_q, seen_d;
  logic [REG_ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic                      regwr_q, regwr_d;
  logic                      memrd_q, memrd_d;
  logic                      memwr_q, memwr_d;
  logic [DATA_WIDTH-1:0]     store_q, store_d;

  always_comb begin
    valid_d   = valid_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
    seen_d    = seen_q;
    wreg_d    = wreg_q;
    regwr_d   = regwr_q;
    memrd_d   = memrd_q;
    memwr_d   = memwr_q;
    store_d   = store_q;
    if (flush || (!stall && !inValid)) begin
      // Bubble; zero stays consistent with the forced-zero result.
      valid_d   = 1'b0;
      result_d  = '0;
      zero_d    = 1'b1;
      ovf_d     = 1'b0;
      illegal_d = 1'b0;
      wreg_d    = '0;
      regwr_d   = 1'b0;
      memrd_d   = 1'b0;
      memwr_d   = 1'b0;
      store_d   = '0;
    end else if (!stall) begin
      valid_d   = 1'b1;
      result_d  = core_illegal ? '0 : core_result;
      zero_d    = core_illegal ? 1'b1 : (core_result == '0);
      ovf_d     = core_overflow;
      illegal_d = core_illegal;
      seen_d    = seen_q | core_illegal;
      wreg_d    = writeRegIn;
      regwr_d   = regWriteIn & ~core_illegal;
      memrd_d   = memReadIn & ~core_illegal;
      memwr_d   = memWriteIn & ~core_illegal;
      store_d   = storeDataIn;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      seen_q    <= 1'b0;
      wreg_q    <= '0;
      regwr_q   <= 1'b0;
      memrd_q   <= 1'b0;
      memwr_q   <= 1'b0;
      store_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
      seen_q    <= seen_d;
      wreg_q    <= wreg_d;
      regwr_q   <= regwr_d;
      memrd_q   <= memrd_d;
      memwr_q   <= memwr_d;
      store_q   <= store_d;
    end
  end

  assign outValid     = valid_q;
  assign aluResult    = result_q;
  assign zero         = zero_q;
  assign overflow     = ovf_q;
  assign illegalOp    = illegal_q;
  assign illegalSeen  = seen_q;
  assign writeRegOut  = wreg_q;
  assign regWriteOut  = regwr_q;
  assign memReadOut   = memrd_q;
  assign memWriteOut  = memwr_q;
  assign storeDataOut = store_q;

endmodule
